// File: rtl/letter_scroller_if.sv
`default_nettype none
// ============================================================================
//  Module      : letter_scroller_if
//  Description : Bundles the letter scroller's control strobes, write port
//                and display/status outputs. The master modport drives the
//                strobes; the slave modport is the scroller itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface letter_scroller_if;
   logic       wr_en;
   logic [4:0] wr_data;
   logic       start;
   logic       stop;
   logic       clear;
   logic [4:0] d;
   logic [3:0] an;
   logic       busy;
   logic       full;
   logic       wrap;

   modport master (
      output wr_en, wr_data, start, stop, clear,
      input  d, an, busy, full, wrap
   );

   modport slave (
      input  wr_en, wr_data, start, stop, clear,
      output d, an, busy, full, wrap
   );
endinterface
`default_nettype wire

// File: rtl/letter_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : letter_scroller
//  Description : Stores up to MSG_DEPTH 5-bit letter codes and scrolls them
//                across a 4-digit multiplexed display. The message is
//                followed by four blank positions so it scrolls fully off
//                before reappearing.
//  Revision    : 1.0  initial release
// ============================================================================
module letter_scroller #(
   parameter int MSG_DEPTH  = 16,
   parameter int SCAN_DIV   = 100000,
   parameter int SCROLL_DIV = 25000000
) (
   input  wire               clk,
   input  wire               rst,
   letter_scroller_if.slave  bus
);

   localparam int SCAN_W   = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
   localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
   localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
   localparam logic [5:0]          DEPTH       = 6'(MSG_DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_SCROLL = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [5:0]          len_q, len_d;
   logic [5:0]          pos_q, pos_d;
   logic [1:0]          k_q, k_d;
   logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
   logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;
   logic [4:0]          d_q, d_d;
   logic [3:0]          an_q, an_d;
   logic                wrap_q, wrap_d;
   logic                mem_we;
   logic [4:0]          mem_q [MSG_DEPTH];

   // Ring length and displayed index are 6/7 bits wide so len+4+3 never overflows.
   logic [5:0]          ring_len;
   logic [6:0]          idx_raw;
   logic [6:0]          idx;
   logic [4:0]          rd_code;

   assign bus.d    = d_q;
   assign bus.an   = an_q;
   assign bus.busy = (state_q == ST_SCROLL);
   assign bus.full = (len_q == DEPTH);
   assign bus.wrap = wrap_q;

   // State register and all reset-able datapath flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         pos_q        <= '0;
         k_q          <= '0;
         scan_cnt_q   <= '0;
         scroll_cnt_q <= '0;
         d_q          <= '0;
         an_q         <= 4'b1111;
         wrap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         pos_q        <= pos_d;
         k_q          <= k_d;
         scan_cnt_q   <= scan_cnt_d;
         scroll_cnt_q <= scroll_cnt_d;
         d_q          <= d_d;
         an_q         <= an_d;
         wrap_q       <= wrap_d;
      end
   end

   // Message buffer: not reset, its contents are hidden while len is 0.
   always_ff @(posedge clk) begin
      for (int j = 0; j < MSG_DEPTH; j++) begin
         if (mem_we && (len_q == 6'(j))) begin
            mem_q[j] <= bus.wr_data;
         end
      end
   end

   // Next-state logic: clear beats everything, stop beats start.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      pos_d        = pos_q;
      k_d          = k_q;
      scan_cnt_d   = scan_cnt_q;
      scroll_cnt_d = scroll_cnt_q;
      wrap_d       = 1'b0;
      mem_we       = 1'b0;

      if (bus.clear) begin
         state_d      = ST_IDLE;
         len_d        = '0;
         pos_d        = '0;
         k_d          = '0;
         scan_cnt_d   = '0;
         scroll_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.wr_en && (len_q < DEPTH)) begin
                  mem_we = 1'b1;
                  len_d  = len_q + 6'd1;
               end
               if (bus.start && !bus.stop && (len_q != 6'd0)) begin
                  state_d      = ST_SCROLL;
                  pos_d        = '0;
                  k_d          = '0;
                  scan_cnt_d   = '0;
                  scroll_cnt_d = '0;
               end
            end
            ST_SCROLL: begin
               if (bus.stop) begin
                  state_d      = ST_IDLE;
                  pos_d        = '0;
                  k_d          = '0;
                  scan_cnt_d   = '0;
                  scroll_cnt_d = '0;
               end else begin
                  if (scan_cnt_q == SCAN_LAST) begin
                     scan_cnt_d = '0;
                     k_d        = k_q + 2'd1;
                  end else begin
                     scan_cnt_d = scan_cnt_q + 1'b1;
                  end
                  if (scroll_cnt_q == SCROLL_LAST) begin
                     scroll_cnt_d = '0;
                     if (pos_q == ring_len - 6'd1) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                     end else begin
                        pos_d  = pos_q + 6'd1;
                     end
                  end else begin
                     scroll_cnt_d = scroll_cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Display lookup: ring index for digit k, then register d/an together.
   always_comb begin
      ring_len = len_q + 6'd4;
      idx_raw  = {1'b0, pos_q} + {5'b0, k_q};
      idx      = (idx_raw >= {1'b0, ring_len}) ? (idx_raw - {1'b0, ring_len}) : idx_raw;
      rd_code  = '0;
      for (int j = 0; j < MSG_DEPTH; j++) begin
         if ((idx == 7'(j)) && (idx < {1'b0, len_q})) begin
            rd_code = mem_q[j];
         end
      end
      d_d  = '0;
      an_d = 4'b1111;
      if (state_q == ST_SCROLL) begin
         d_d = rd_code;
         case (k_q)
            2'd0:    an_d = 4'b0111;
            2'd1:    an_d = 4'b1011;
            2'd2:    an_d = 4'b1101;
            default: an_d = 4'b1110;
         endcase
      end
   end

endmodule
`default_nettype wire
